// File: rtl/video_timing_gen.sv
// Raster timing generator: walks active/front-porch/sync/back-porch on both axes under i_en.
// Optional completed-frame counter on o_frame_cnt when VTG_FRAME_CNT_EN is defined.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   FCNT_W   = 16,
  localparam int  HTOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  VTOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HLEN     = $clog2(HTOTAL),
  localparam int  VLEN     = $clog2(VTOTAL)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_en,
  input  logic              i_restart,
  output logic [HLEN-1:0]   o_hcount,
  output logic [VLEN-1:0]   o_vcount,
  output logic              o_de,
  output logic              o_hblank,
  output logic              o_vblank,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_frame_start,
  output logic              o_line_end,
  output logic              o_frame_end
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [FCNT_W-1:0] o_frame_cnt
`endif
);

  // Sync windows use an inclusive last index so a zero back porch never needs HTOTAL itself.
  localparam logic [HLEN-1:0] C_HLAST     = HLEN'(HTOTAL - 1);
  localparam logic [VLEN-1:0] C_VLAST     = VLEN'(VTOTAL - 1);
  localparam logic [HLEN-1:0] C_HACT      = HLEN'(H_ACTIVE);
  localparam logic [VLEN-1:0] C_VACT      = VLEN'(V_ACTIVE);
  localparam logic [HLEN-1:0] C_HS_FIRST  = HLEN'(H_ACTIVE + H_FP);
  localparam logic [HLEN-1:0] C_HS_LAST   = HLEN'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VLEN-1:0] C_VS_FIRST  = VLEN'(V_ACTIVE + V_FP);
  localparam logic [VLEN-1:0] C_VS_LAST   = VLEN'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HLEN-1:0] r_hc;
  logic [VLEN-1:0] r_vc;

  logic w_hlast;
  logic w_vlast;
  logic w_advance;
  logic w_hsync_act;
  logic w_vsync_act;

  assign w_hlast   = (r_hc == C_HLAST);
  assign w_vlast   = (r_vc == C_VLAST);
  assign w_advance = i_en & ~i_restart;

  always_ff @(posedge clk) begin
    if (!rstn || i_restart) begin
      r_hc <= C_HLAST;
      r_vc <= C_VLAST;
    end else if (i_en) begin
      if (w_hlast) begin
        r_hc <= '0;
        r_vc <= w_vlast ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

  assign w_hsync_act = (r_hc >= C_HS_FIRST) && (r_hc <= C_HS_LAST);
  assign w_vsync_act = (r_vc >= C_VS_FIRST) && (r_vc <= C_VS_LAST);

  assign o_hcount      = r_hc;
  assign o_vcount      = r_vc;
  assign o_hblank      = (r_hc >= C_HACT);
  assign o_vblank      = (r_vc >= C_VACT);
  assign o_de          = ~o_hblank & ~o_vblank;
  assign o_hsync       = w_hsync_act ? H_POL : ~H_POL;
  assign o_vsync       = w_vsync_act ? V_POL : ~V_POL;
  assign o_frame_start = (r_hc == '0) && (r_vc == '0);
  // A restart cancels the wrap, so the strobes are suppressed along with the advance.
  assign o_line_end    = rstn & w_advance & w_hlast;
  assign o_frame_end   = o_line_end & w_vlast;

`ifdef VTG_FRAME_CNT_EN
  logic [FCNT_W-1:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (!rstn || i_restart) begin
      r_frame_cnt <= '0;
    end else if (o_frame_end) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: linear-position reference model checked every cycle,
// plus literal expectations; small raster so whole frames fit in a short run.
module tb_video_timing_gen;

  localparam int   H_ACTIVE = 4;
  localparam int   H_FP     = 1;
  localparam int   H_SYNC   = 2;
  localparam int   H_BP     = 1;
  localparam int   V_ACTIVE = 2;
  localparam int   V_FP     = 1;
  localparam int   V_SYNC   = 1;
  localparam int   V_BP     = 1;
  localparam logic H_POL    = 1'b0;
  localparam logic V_POL    = 1'b1;
  localparam int   FCNT_W   = 2;
  localparam int   HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   TOT      = HT * VT;
  localparam int   HLEN     = $clog2(HT);
  localparam int   VLEN     = $clog2(VT);

  logic            clk = 1'b0;
  logic            rstn;
  logic            i_en;
  logic            i_restart;
  logic [HLEN-1:0] o_hcount;
  logic [VLEN-1:0] o_vcount;
  logic            o_de, o_hblank, o_vblank, o_hsync, o_vsync;
  logic            o_frame_start, o_line_end, o_frame_end;
`ifdef VTG_FRAME_CNT_EN
  logic [FCNT_W-1:0] o_frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int mPos;
  int mFcnt;
  int lineEnds;
  int frameEnds;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_en(i_en),
    .i_restart(i_restart),
    .o_hcount(o_hcount),
    .o_vcount(o_vcount),
    .o_de(o_de),
    .o_hblank(o_hblank),
    .o_vblank(o_vblank),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_frame_start(o_frame_start),
    .o_line_end(o_line_end),
    .o_frame_end(o_frame_end)
`ifdef VTG_FRAME_CNT_EN
    ,
    .o_frame_cnt(o_frame_cnt)
`endif
  );

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs come from the linear raster index mPos = vc*HT + hc.
  task automatic checkOutput();
    int hc, vc, expHs, expVs, le, fe;
    hc = mPos % HT;
    vc = mPos / HT;
    expHs = (hc >= H_ACTIVE + H_FP && hc < H_ACTIVE + H_FP + H_SYNC) ? int'(H_POL) : int'(!H_POL);
    expVs = (vc >= V_ACTIVE + V_FP && vc < V_ACTIVE + V_FP + V_SYNC) ? int'(V_POL) : int'(!V_POL);
    le = (rstn && i_en && !i_restart && hc == HT - 1) ? 1 : 0;
    fe = (le == 1 && vc == VT - 1) ? 1 : 0;
    cmp("hcount", int'(o_hcount), hc);
    cmp("vcount", int'(o_vcount), vc);
    cmp("hblank", int'(o_hblank), (hc >= H_ACTIVE) ? 1 : 0);
    cmp("vblank", int'(o_vblank), (vc >= V_ACTIVE) ? 1 : 0);
    cmp("de", int'(o_de), (hc < H_ACTIVE && vc < V_ACTIVE) ? 1 : 0);
    cmp("hsync", int'(o_hsync), expHs);
    cmp("vsync", int'(o_vsync), expVs);
    cmp("frame_start", int'(o_frame_start), (mPos == 0) ? 1 : 0);
    cmp("line_end", int'(o_line_end), le);
    cmp("frame_end", int'(o_frame_end), fe);
`ifdef VTG_FRAME_CNT_EN
    cmp("frame_cnt", int'(o_frame_cnt), mFcnt);
`endif
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit rs);
    @(negedge clk);
    rstn = r;
    i_en = e;
    i_restart = rs;
    #1;
    checkOutput();
    if (o_line_end === 1'b1) lineEnds++;
    if (o_frame_end === 1'b1) frameEnds++;
    if (!r || rs) begin
      mPos = TOT - 1;
      mFcnt = 0;
    end else if (e) begin
      if (mPos == TOT - 1) mFcnt = (mFcnt + 1) % (1 << FCNT_W);
      mPos = (mPos + 1) % TOT;
    end
  endtask

  initial begin
    rstn = 1'b0;
    i_en = 1'b0;
    i_restart = 1'b0;
    mPos = TOT - 1;
    mFcnt = 0;
    lineEnds = 0;
    frameEnds = 0;
    repeat (3) @(posedge clk);

    // Reset held with i_en high: strobes must stay low at the last pixel.
    applyStimulus(1'b0, 1'b1, 1'b0);
    cmp("rst_hcount_lit", int'(o_hcount), 7);
    cmp("rst_vcount_lit", int'(o_vcount), 4);
    cmp("rst_line_end_lit", int'(o_line_end), 0);
    cmp("rst_vsync_lit", int'(o_vsync), 0);

    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    cmp("first_hcount_lit", int'(o_hcount), 0);
    cmp("first_vcount_lit", int'(o_vcount), 0);
    cmp("first_frame_start_lit", int'(o_frame_start), 1);
    cmp("first_de_lit", int'(o_de), 1);

    // Two full frames at constant enable.
    lineEnds = 0;
    frameEnds = 0;
    repeat (2 * TOT) applyStimulus(1'b1, 1'b1, 1'b0);
    cmp("cont_line_ends_lit", lineEnds, 10);
    cmp("cont_frame_ends_lit", frameEnds, 2);

    // Gapped enable, 1 of every 3 cycles, for exactly one frame of advances.
    lineEnds = 0;
    frameEnds = 0;
    for (int i = 0; i < 3 * TOT; i++) applyStimulus(1'b1, (i % 3) == 0, 1'b0);
    cmp("gap_line_ends_lit", lineEnds, 5);
    cmp("gap_frame_ends_lit", frameEnds, 1);

    // Restart exactly on a line wrap: the wrap and its strobe are cancelled.
    while ((mPos % HT) != HT - 1 || (mPos / HT) != 2) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    cmp("restart_line_end_lit", int'(o_line_end), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    cmp("restart_hcount_lit", int'(o_hcount), 7);
    cmp("restart_vcount_lit", int'(o_vcount), 4);
`ifdef VTG_FRAME_CNT_EN
    cmp("restart_fcnt_lit", int'(o_frame_cnt), 0);
`endif

    // Five frames so the 2-bit frame counter wraps.
    repeat (5 * TOT + 2) applyStimulus(1'b1, 1'b1, 1'b0);

    // Randomized enable, occasional restart bursts and resets.
    for (int i = 0; i < 1500; i++) begin
      int pick;
      pick = int'($urandom_range(0, 99));
      if (pick < 2) applyStimulus(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      else if (pick < 6) applyStimulus(1'b1, $urandom_range(0, 1) == 1, 1'b1);
      else applyStimulus(1'b1, $urandom_range(0, 9) < 7, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI transmitter. It is the successor to the bare h/v position counter. It walks a full raster (active, front porch, sync, back porch) on both axes under a pixel-advance enable. From the position it produces data-enable, blanking, polarity-configurable sync, and line/frame strobes, which feed the TMDS encoder and the pixel source.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- FCNT_W, 16, frame counter width (used only with VTG_FRAME_CNT_EN)
- Derived: HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; VTOTAL likewise; HLEN = $clog2(HTOTAL); VLEN = $clog2(VTOTAL)

Ports:
- clk  in  1  pixel clock
- rstn  in  1  reset, synchronous, active-low
- i_en  in  1  advance position by one pixel this cycle
- i_restart  in  1  synchronous restart; next advance lands on (0,0)
- o_hcount  out  HLEN  current pixel column
- o_vcount  out  VLEN  current line
- o_de  out  1  active video
- o_hblank  out  1  hcount >= H_ACTIVE
- o_vblank  out  1  vcount >= V_ACTIVE
- o_hsync  out  1  horizontal sync, level per H_POL
- o_vsync  out  1  vertical sync, level per V_POL
- o_frame_start  out  1  position is (0,0)
- o_line_end  out  1  line wraps this cycle
- o_frame_end  out  1  frame wraps this cycle
- o_frame_cnt  out  FCNT_W  completed frames (VTG_FRAME_CNT_EN only)

## Operation
- Counters hc and vc are the only position state. The outputs o_hcount and o_vcount are these registers directly.
- Reset and restart both load hc = HTOTAL-1 and vc = VTOTAL-1, the last back-porch pixel. The first i_en after either therefore enters (0,0).
- Priority: rstn low > i_restart > i_en > hold.
- Advance on i_en:
  - hc increments; if hc == HTOTAL-1, hc goes to 0 and the line advances.
  - On a line advance, vc increments; if vc == VTOTAL-1, vc goes to 0.
- Counters hold when i_en is low.
- Region decode is combinational from hc and vc:
  - o_hblank = hc >= H_ACTIVE; o_vblank = vc >= V_ACTIVE; o_de = !o_hblank && !o_vblank.
  - hsync active when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; o_hsync = active ? H_POL : !H_POL.
  - vsync active when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; vsync is line-based and changes coincident with hc wrapping to 0.
  - o_frame_start = (hc==0 && vc==0).
  - o_line_end = rstn && i_en && hc==HTOTAL-1.
  - o_frame_end = o_line_end && vc==VTOTAL-1.
- Reset values: o_hcount = HTOTAL-1, o_vcount = VTOTAL-1, o_de = 0, o_hblank = 1, o_vblank = 1, o_hsync = !H_POL, o_vsync = !V_POL, o_frame_start = 0, o_line_end = 0, o_frame_end = 0, o_frame_cnt = 0.
- Arithmetic: all comparisons use constants truncated to HLEN/VLEN. Parameters must give H_SYNC, V_SYNC, H_ACTIVE, V_ACTIVE >= 1; porches may be 0.
- i_restart asserted together with i_en: restart wins, no advance, and no line_end/frame_end is emitted.
- i_restart held: position stays pinned at the last pixel.

## Timing
- Counter latency: 1 cycle from an i_en edge to the new position. Decode has zero latency relative to the counters.
- With i_en constant high:
  - o_de high for H_ACTIVE consecutive cycles per active line.
  - o_line_end is a 1-cycle pulse every HTOTAL cycles.
  - o_frame_end is a 1-cycle pulse every HTOTAL*VTOTAL cycles.
  - o_frame_start is high the cycle after o_frame_end.
- With gapped i_en, o_frame_start is a level lasting while (0,0) is held. Strobes fire only on the advancing cycle.

## Configuration
- VTG_FRAME_CNT_EN defined:
  - o_frame_cnt exists.
  - It increments on o_frame_end and wraps at 2^FCNT_W.
  - It is cleared by rstn and by i_restart.
  - When a frame_end is cancelled by i_restart, it does not count.
- VTG_FRAME_CNT_EN undefined: the port and register are absent; all other behaviour is identical.

## Test plan
- Reset with defaults → hcount=799, vcount=524, de=0, hsync=vsync=1, strobes 0; first i_en cycle → (0,0), frame_start=1, de=1.
- i_en constant, one line → de high for hc 0..639, hsync low for hc 656..751, line_end pulse at hc=799, vcount 0→1 on the next cycle.
- Full frame at defaults → vsync low for vc 490..491, vblank for vc 480..524, frame_end once per 420000 cycles, then wrap to (0,0).
- i_en toggled 1-of-3 with small params (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1) → position advances only on enabled cycles; line_end fires once per 8 advances; frame_end once per 40 advances.
- i_restart at (300,200) with i_en=1 → next cycle (799,524), no strobes; following advance → (0,0) with frame_start=1.
- VTG_FRAME_CNT_EN, FCNT_W=2, small params → frame_cnt 0,1,2,3,0 across five frames; restart clears it to 0.
